// File: rtl/rr_mux_arbiter_pkg.sv
// Shared arbiter definitions: FSM state encoding reused by the arbiter family.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin mux arbiter.
interface rr_mux_arbiter_if #(
  parameter int INs = 5,
  parameter int SW  = $clog2(INs)
);

  logic [INs-1:0] req;
  logic           done;
  logic [INs-1:0] gnt;
  logic [SW-1:0]  sel;
  logic           busy;

  modport master (output req, done, input gnt, sel, busy);
  modport slave  (input req, done, output gnt, sel, busy);

endinterface

// File: rtl/rr_mux_arbiter_pick.sv
// Rotating-priority search: first set req bit strictly after ptr, wrapping modulo INs.
module rr_pick #(
  parameter int INs = 5,
  parameter int SW  = $clog2(INs)
) (
  input  logic [INs-1:0] req,
  input  logic [SW-1:0]  ptr,
  output logic           found,
  output logic [SW-1:0]  idx
);

  localparam int unsigned N = INs;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    // Offsets 1..N visit ptr+1 first and ptr itself last.
    for (int unsigned i = 1; i <= N; i++) begin
      int unsigned c;
      c = (32'(ptr) + i) % N;
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = SW'(c);
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin owner arbiter for a shared mux: IDLE/GRANT FSM, release pointer, registered outputs.
module rr_mux_arbiter
  import arb_pkg::*;
#(
  parameter int INs = 5,
  parameter int SW  = $clog2(INs)
) (
  input  logic               clk,
  input  logic               reset,
  rr_mux_arbiter_if.slave    bus
);

  state_t         state, state_n;
  logic [SW-1:0]  ptr, ptr_n;
  logic [INs-1:0] gnt, gnt_n;
  logic [SW-1:0]  sel, sel_n;
  logic           busy, busy_n;
  logic           found;
  logic [SW-1:0]  idx;

  rr_pick #(.INs(INs), .SW(SW)) u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .found (found),
    .idx   (idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= SW'(INs - 1);
      gnt   <= '0;
      sel   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      gnt   <= gnt_n;
      sel   <= sel_n;
      busy  <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gnt_n   = gnt;
    sel_n   = sel;
    busy_n  = busy;
    unique case (state)
      IDLE: begin
        gnt_n  = '0;
        busy_n = 1'b0;
        if (found) begin
          state_n    = GRANT;
          gnt_n      = '0;
          gnt_n[idx] = 1'b1;
          sel_n      = idx;
          busy_n     = 1'b1;
        end
      end
      GRANT: begin
        // Release leaves sel on the last owner; ptr records it for the next search.
        if (bus.done || !bus.req[sel]) begin
          state_n = IDLE;
          gnt_n   = '0;
          busy_n  = 1'b0;
          ptr_n   = sel;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.gnt  = gnt;
  assign bus.sel  = sel;
  assign bus.busy = busy;

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001: Parameter INs, default 5, is the number of requesters sharing the generic 1-bit mux; legal range is 2..32.
REQ-002: Parameter SW, default $clog2(INs), is the select width, matching the mux select port.
REQ-003: Port clk, input, 1 bit, is the single clock; all state updates on its rising edge.
REQ-004: Port reset, input, 1 bit, is the synchronous, active-high reset.
REQ-005: Port req, input, INs bits, has one request line per requester; bit i high means requester i wants the mux.
REQ-006: Port done, input, 1 bit, is asserted by the current owner to release the mux; it is sampled only in GRANT.
REQ-007: Port gnt, output, INs bits, is the one-hot grant, or all zeros when no requester owns the mux.
REQ-008: Port sel, output, SW bits, is the binary index of the granted requester and drives the mux select port directly.
REQ-009: Port busy, output, 1 bit, is high while a grant is held.

Function
REQ-010: The FSM SHALL have two states, IDLE and GRANT.
REQ-011: In IDLE with req nonzero, the block SHALL pick the first set req bit searching upward from ptr+1, modulo INs, with wrap-around.
- In the next cycle: gnt = onehot(winner), sel = winner, busy = 1, state = GRANT.
- Arbitration latency is 1 clock.
REQ-012: In IDLE with req == 0, the block SHALL hold gnt = 0, busy = 0, sel unchanged, and ptr unchanged.
REQ-013: In GRANT, the block SHALL hold gnt, sel and busy stable regardless of other req bits.
REQ-014: In GRANT, if done = 1 or req[sel] = 0, the block SHALL release on that edge.
- Next cycle: gnt = 0, busy = 0, ptr = sel, state = IDLE.
- sel keeps the last owner index.
REQ-015: Every grant SHALL be followed by exactly one IDLE cycle before the next grant, even when requests are pending.
REQ-016: done asserted in IDLE SHALL be ignored.
REQ-017: gnt SHALL never have more than one bit set, and sel SHALL never exceed INs-1.
REQ-018: Simultaneous done and a new req in the same GRANT cycle SHALL release first; the new req is arbitrated in the following IDLE cycle.
REQ-019: With only one requester active, the block SHALL grant that requester repeatedly, one IDLE cycle apart.
REQ-020: All outputs SHALL be registered, with no combinational path from req or done to gnt, sel or busy.

Reset
REQ-021: When reset = 1 at a clk edge, the block SHALL set state = IDLE, gnt = 0, sel = 0, busy = 0 and ptr = INs-1, so requester 0 has the highest first priority.
REQ-022: Reset SHALL override any in-progress grant; the grant drops on the same edge and no release pointer update occurs.
REQ-023: Reset SHALL take priority over done and req.

Structure
REQ-024: Shared package arb_pkg SHALL hold the state encoding constants (IDLE = 0, GRANT = 1) for reuse by later arbiters.
REQ-025: Combinational sub-module rr_pick (inputs req and ptr; outputs found and idx) SHALL implement the rotating priority search and be instantiated once.
REQ-026: rr_mux_arbiter SHALL hold only the FSM, the ptr register and the output registers.

Verification
REQ-027: The bench SHALL cover this reset case.
- Stimulus: reset = 1 for 2 cycles with req = 5'b11111.
- Required response: gnt = 0, sel = 0, busy = 0.
- First grant after reset release is gnt = 5'b00001.
REQ-028: The bench SHALL cover this rotation case with INs = 5.
- Stimulus: req = 5'b10101 held; done pulsed 1 cycle in each GRANT.
- Required sel sequence: 0, 2, 4, 0, with one busy = 0 cycle between grants.
REQ-029: The bench SHALL cover this single-requester case.
- Stimulus: req = 5'b01000; done pulsed each grant.
- Required response: gnt = 5'b01000 and sel = 3 every grant, alternating with gnt = 0.
REQ-030: The bench SHALL cover this drop-request case.
- Stimulus: owner 2 deasserts req[2] with done = 0.
- Required response: next cycle gnt = 0 and busy = 0; then the next pending higher index after 2 is granted.
REQ-031: The bench SHALL cover this mid-grant reset case.
- Stimulus: reset pulsed while gnt = 5'b00100, req = 5'b10001.
- Required response: gnt = 0 next edge; the first post-reset grant is 5'b00001, not 5'b10000.
REQ-032: The bench SHALL cover this stray-done case.
- Stimulus: done = 1 with req = 0 for 3 cycles.
- Required response: busy stays 0, gnt stays 0, and ptr is unchanged (checked via the next grant order).
